cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller for a small CPU pipeline, with PC breakpoints and a
// debug port that takes over the register-file read port while halted.
module cpu_run_ctrl #(
  parameter int PC_W        = 8,
  parameter int NUM_BP      = 2,
  parameter int STEP_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   PAUSE,
  input  logic                   STEP,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0]        cpu_pc,
  input  logic                   dbg_req,
  input  logic [3:0]             dbg_ra,
  output logic                   cpu_en,
  output logic                   halted,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic                   dbg_grant,
  output logic                   rf_sel,
  output logic [3:0]             rf_ra
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2,
    ST_DBG  = 2'd3
  } state_t;

  localparam logic [7:0] LP_STEP_LOAD = 8'(STEP_CYCLES);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_pause_sync;
  logic [SYNC_STAGES-1:0] r_step_sync;
  logic                   r_step_prev;
  logic                   r_cpu_en;
  logic                   r_halted;
  logic [NUM_BP-1:0]      r_bp_hit;
  logic                   r_dbg_grant;
  logic                   r_rf_sel;
  logic [3:0]             r_rf_ra;
  logic [7:0]             r_step_cnt;
  logic                   r_step_pend;

  logic                   w_pause;
  logic                   w_step;
  logic                   w_step_edge;
  logic [NUM_BP-1:0]      w_bp_match;

  assign w_pause     = r_pause_sync[SYNC_STAGES-1];
  assign w_step      = r_step_sync[SYNC_STAGES-1];
  assign w_step_edge = w_step & ~r_step_prev;

  // Synchronise the asynchronous PAUSE level and STEP button into CLK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pause_sync <= {SYNC_STAGES{1'b0}};
      r_step_sync  <= {SYNC_STAGES{1'b0}};
      r_step_prev  <= 1'b0;
    end else begin
      r_pause_sync <= {r_pause_sync[SYNC_STAGES-2:0], PAUSE};
      r_step_sync  <= {r_step_sync[SYNC_STAGES-2:0], STEP};
      r_step_prev  <= w_step;
    end
  end

  // Per-comparator PC match; the FSM only looks at it while running.
  always_comb begin
    w_bp_match = {NUM_BP{1'b0}};
    for (int i = 0; i < NUM_BP; i++) begin
      w_bp_match[i] = bp_en[i] && (cpu_pc == bp_addr[i*PC_W +: PC_W]);
    end
  end

  // Run-control FSM; every output is registered alongside the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_RUN;
      r_cpu_en    <= 1'b1;
      r_halted    <= 1'b0;
      r_bp_hit    <= {NUM_BP{1'b0}};
      r_dbg_grant <= 1'b0;
      r_rf_sel    <= 1'b0;
      r_rf_ra     <= 4'd0;
      r_step_cnt  <= 8'd0;
      r_step_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_pause || (|w_bp_match)) begin
            r_state  <= ST_HALT;
            r_cpu_en <= 1'b0;
            r_halted <= 1'b1;
            r_bp_hit <= w_bp_match;
          end
        end

        ST_HALT: begin
          // Step requests collapse into one pending flag; taking the step clears it.
          r_step_pend <= r_step_pend | w_step_edge;
          if (dbg_req) begin
            r_state     <= ST_DBG;
            r_rf_sel    <= 1'b1;
            r_rf_ra     <= dbg_ra;
            r_dbg_grant <= 1'b0;
          end else if (r_step_pend) begin
            r_state     <= ST_STEP;
            r_cpu_en    <= 1'b1;
            r_halted    <= 1'b0;
            r_step_cnt  <= LP_STEP_LOAD;
            r_bp_hit    <= {NUM_BP{1'b0}};
            r_step_pend <= 1'b0;
          end else if (!w_pause && (r_bp_hit == {NUM_BP{1'b0}})) begin
            r_state  <= ST_RUN;
            r_cpu_en <= 1'b1;
            r_halted <= 1'b0;
          end
        end

        ST_STEP: begin
          r_step_cnt <= r_step_cnt - 8'd1;
          if (r_step_cnt <= 8'd1) begin
            r_state  <= ST_HALT;
            r_cpu_en <= 1'b0;
            r_halted <= 1'b1;
          end
        end

        ST_DBG: begin
          r_step_pend <= r_step_pend | w_step_edge;
          if (!dbg_req) begin
            r_state     <= ST_HALT;
            r_rf_sel    <= 1'b0;
            r_dbg_grant <= 1'b0;
          end else if (dbg_ra != r_rf_ra) begin
            r_rf_ra     <= dbg_ra;
            r_dbg_grant <= 1'b0;
          end else begin
            r_dbg_grant <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_RUN;
          r_cpu_en    <= 1'b1;
          r_halted    <= 1'b0;
          r_dbg_grant <= 1'b0;
          r_rf_sel    <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_en    = r_cpu_en;
  assign halted    = r_halted;
  assign bp_hit    = r_bp_hit;
  assign dbg_grant = r_dbg_grant;
  assign rf_sel    = r_rf_sel;
  assign rf_ra     = r_rf_ra;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: expected output vectors go into a scoreboard
// queue as each step is driven and are popped and compared after the clock edge.
module tb_cpu_run_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       PAUSE;
  logic       STEP;
  logic [1:0] bp_en;
  logic [15:0] bp_addr;
  logic [7:0] cpu_pc;
  logic       dbg_req;
  logic [3:0] dbg_ra;
  logic       cpu_en;
  logic       halted;
  logic [1:0] bp_hit;
  logic       dbg_grant;
  logic       rf_sel;
  logic [3:0] rf_ra;

  int checks   = 0;
  int failures = 0;
  bit pc_run   = 1'b0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;

  sb_t sb_q[$];

  cpu_run_ctrl #(
    .PC_W        (8),
    .NUM_BP      (2),
    .STEP_CYCLES (3),
    .SYNC_STAGES (2)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PAUSE     (PAUSE),
    .STEP      (STEP),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .cpu_pc    (cpu_pc),
    .dbg_req   (dbg_req),
    .dbg_ra    (dbg_ra),
    .cpu_en    (cpu_en),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .dbg_grant (dbg_grant),
    .rf_sel    (rf_sel),
    .rf_ra     (rf_ra)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  // Output vector layout: {cpu_en, halted, bp_hit[1:0], dbg_grant, rf_sel, rf_ra[3:0]}
  function automatic logic [9:0] mk(input logic c, input logic h, input logic [1:0] bp,
                                    input logic g, input logic s, input logic [3:0] ra);
    return {c, h, bp, g, s, ra};
  endfunction

  task automatic compare_head();
    sb_t        e;
    logic [9:0] obs;
    e   = sb_q.pop_front();
    obs = {cpu_en, halted, bp_hit, dbg_grant, rf_sel, rf_ra};
    checks++;
    assert (obs === e.exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (pc_run && cpu_en) cpu_pc = cpu_pc + 8'd1;
  endtask

  task automatic push_exp(input string tag, input logic [9:0] e);
    sb_t item;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic expect_cycle(input string tag, input logic [9:0] e);
    push_exp(tag, e);
    tick();
    compare_head();
  endtask

  task automatic expect_now(input string tag, input logic [9:0] e);
    push_exp(tag, e);
    compare_head();
  endtask

  task automatic check_int(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] e_run, e_hlt, e_bph, e_hlt9, e_stp9, e_grt9;
    e_run  = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
    e_hlt  = mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
    e_bph  = mk(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'h0);
    e_hlt9 = mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h9);
    e_stp9 = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'h9);
    e_grt9 = mk(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 4'h9);

    RST_N   = 1'b1;
    PAUSE   = 1'b0;
    STEP    = 1'b0;
    bp_en   = 2'b00;
    bp_addr = 16'h0000;
    cpu_pc  = 8'h00;
    dbg_req = 1'b0;
    dbg_ra  = 4'h0;

    // Reset hold and release with PAUSE low
    #2 RST_N = 1'b0;
    #1 expect_now("rst_async", e_run);
    expect_cycle("rst_hold_clk", e_run);
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) expect_cycle("run_after_rst", e_run);

    // PAUSE reaches the FSM after the synchroniser, then one 3-cycle step
    PAUSE = 1'b1;
    expect_cycle("pause_sync1", e_run);
    expect_cycle("pause_sync2", e_run);
    expect_cycle("pause_halt", e_hlt);
    STEP = 1'b1;
    expect_cycle("step_sync1", e_hlt);
    expect_cycle("step_sync2", e_hlt);
    STEP = 1'b0;
    expect_cycle("step_pend", e_hlt);
    for (int k = 0; k < 3; k++) expect_cycle("step_cycle", e_run);
    expect_cycle("step_done", e_hlt);
    expect_cycle("step_stay_halt", e_hlt);

    // Breakpoint on comparator 1 at PC 8'h14
    PAUSE   = 1'b0;
    bp_en   = 2'b10;
    bp_addr = {8'h14, 8'h00};
    cpu_pc  = 8'h10;
    pc_run  = 1'b1;
    expect_cycle("unpause_sync1", e_hlt);
    expect_cycle("unpause_sync2", e_hlt);
    for (int k = 0; k < 4; k++) expect_cycle("bp_run", e_run);
    expect_cycle("bp_halt", e_bph);
    check_int("bp_halt_pc", cpu_pc, 8'h14);
    expect_cycle("bp_no_resume", e_bph);
    expect_cycle("bp_no_resume", e_bph);
    STEP = 1'b1;
    expect_cycle("bp_step_sync", e_bph);
    expect_cycle("bp_step_sync", e_bph);
    STEP = 1'b0;
    expect_cycle("bp_step_pend", e_bph);
    for (int k = 0; k < 3; k++) expect_cycle("bp_step", e_run);
    expect_cycle("bp_step_done", e_hlt);
    expect_cycle("bp_resume", e_run);
    expect_cycle("bp_resume", e_run);
    pc_run = 1'b0;
    bp_en  = 2'b00;

    // Debug request while running is held off
    dbg_req = 1'b1;
    dbg_ra  = 4'h3;
    expect_cycle("dbg_holdoff", e_run);
    expect_cycle("dbg_holdoff", e_run);
    dbg_req = 1'b0;

    // Debug read: entry, grant, relatch, exit
    PAUSE = 1'b1;
    expect_cycle("dbg_pause1", e_run);
    expect_cycle("dbg_pause2", e_run);
    expect_cycle("dbg_pause_halt", e_hlt);
    dbg_req = 1'b1;
    dbg_ra  = 4'h5;
    expect_cycle("dbg_enter", mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'h5));
    expect_cycle("dbg_grant", mk(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 4'h5));
    expect_cycle("dbg_grant_hold", mk(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 4'h5));
    dbg_ra = 4'h9;
    expect_cycle("dbg_relatch", mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'h9));
    expect_cycle("dbg_regrant", e_grt9);
    dbg_req = 1'b0;
    expect_cycle("dbg_exit", e_hlt9);
    expect_cycle("dbg_exit_stay", e_hlt9);

    // Two STEP pulses during DBG collapse into one step after the release
    dbg_req = 1'b1;
    expect_cycle("dbgs_enter", mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'h9));
    STEP = 1'b1;
    expect_cycle("dbgs_grant", e_grt9);
    expect_cycle("dbgs_grant", e_grt9);
    STEP = 1'b0;
    expect_cycle("dbgs_grant", e_grt9);
    expect_cycle("dbgs_grant", e_grt9);
    check_int("dbgs_step_pend", {7'd0, dut.r_step_pend}, 8'd1);
    STEP = 1'b1;
    expect_cycle("dbgs_grant", e_grt9);
    expect_cycle("dbgs_grant", e_grt9);
    STEP = 1'b0;
    expect_cycle("dbgs_grant", e_grt9);
    expect_cycle("dbgs_grant", e_grt9);
    dbg_req = 1'b0;
    expect_cycle("dbgs_exit", e_hlt9);
    for (int k = 0; k < 3; k++) expect_cycle("dbgs_step", e_stp9);
    for (int k = 0; k < 3; k++) expect_cycle("dbgs_single_step", e_hlt9);

    // Reset in the middle of a step
    STEP = 1'b1;
    expect_cycle("rs_sync", e_hlt9);
    expect_cycle("rs_sync", e_hlt9);
    STEP = 1'b0;
    expect_cycle("rs_pend", e_hlt9);
    expect_cycle("rs_step", e_stp9);
    expect_cycle("rs_step", e_stp9);
    RST_N = 1'b0;
    PAUSE = 1'b0;
    #1 expect_now("rs_async", e_run);
    check_int("rs_cnt", dut.r_step_cnt, 8'd0);
    check_int("rs_pend", {7'd0, dut.r_step_pend}, 8'd0);
    expect_cycle("rs_hold", e_run);
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) expect_cycle("rs_post_run", e_run);

    // Reset in the middle of a debug read leaves no grant behind
    PAUSE = 1'b1;
    expect_cycle("rd_pause1", e_run);
    expect_cycle("rd_pause2", e_run);
    expect_cycle("rd_halt", e_hlt);
    dbg_req = 1'b1;
    dbg_ra  = 4'h5;
    expect_cycle("rd_enter", mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 4'h5));
    expect_cycle("rd_grant", mk(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 4'h5));
    RST_N   = 1'b0;
    PAUSE   = 1'b0;
    dbg_req = 1'b0;
    #1 expect_now("rd_async", e_run);
    expect_cycle("rd_hold", e_run);
    RST_N = 1'b1;
    expect_cycle("rd_post_run", e_run);
    expect_cycle("rd_post_run", e_run);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
